// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter with round-robin priority,
// one-cycle registered write port and a saturating dual-request counter.
module regwrite_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              stall,
  input  logic              cnt_clr,
  output logic              ack0,
  output logic              ack1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              grant_id,
  output logic [3:0]        conflict_cnt
);

  logic              pri_q, pri_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              grant_id_q, grant_id_d;
  logic [3:0]        conflict_cnt_q, conflict_cnt_d;

  logic              grant_ok;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant stage: pri only matters when both requesters compete.
  always_comb begin
    grant_ok = ~stall & ~reset;
    ack0     = grant_ok & req0 & (~req1 | ~pri_q);
    ack1     = grant_ok & req1 & (~req0 |  pri_q);
    grant    = ack0 | ack1;
    sel_addr = ack1 ? addr1 : addr0;
    sel_data = ack1 ? data1 : data0;
  end

  always_comb begin
    pri_d          = pri_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    grant_id_d     = grant_id_q;
    conflict_cnt_d = conflict_cnt_q;
    if (grant) begin
      pri_d      = ~ack1;
      wr_en_d    = (sel_addr != ADDR_W'(ZERO_REG));
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      grant_id_d = ack1;
    end
    // Counts contention even while stalled; clear wins over increment.
    if (cnt_clr)
      conflict_cnt_d = 4'd0;
    else if (req0 && req1 && conflict_cnt_q != 4'd15)
      conflict_cnt_d = conflict_cnt_q + 4'd1;
  end

  // Write-port register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q          <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      grant_id_q     <= 1'b0;
      conflict_cnt_q <= 4'd0;
    end else begin
      pri_q          <= pri_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      grant_id_q     <= grant_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign grant_id     = grant_id_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed + random bench for regwrite_arbiter: expected write-port state is
// queued when a cycle is driven and popped after the following clock edge.
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        reset, req0, req1, stall, cnt_clr;
  logic [4:0]  addr0, addr1;
  logic [63:0] data0, data1;
  logic        ack0, ack1, wr_en, grant_id;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  conflict_cnt;

  regwrite_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .stall(stall), .cnt_clr(cnt_clr), .ack0(ack0), .ack1(ack1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_id(grant_id), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        gid;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        m_pri = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  logic        m_gid = 1'b0;
  logic [3:0]  m_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic tick();
    logic g0, g1;
    logic [4:0] a;
    exp_t e, o;
    #3;
    g0 = !reset && !stall && req0 && (!req1 || !m_pri);
    g1 = !reset && !stall && req1 && (!req0 || m_pri);
    chk("ack0", ack0, g0);
    chk("ack1", ack1, g1);
    if (reset) begin
      m_pri = 0; m_addr = '0; m_data = '0; m_gid = 0; m_cnt = '0;
      e.en = 0;
    end else begin
      e.en = 0;
      if (g0 || g1) begin
        a      = g1 ? addr1 : addr0;
        m_data = g1 ? data1 : data0;
        m_addr = a;
        m_gid  = g1;
        m_pri  = !g1;
        e.en   = (a != 5'd31);
      end
      if (cnt_clr) m_cnt = '0;
      else if (req0 && req1 && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
    end
    e.addr = m_addr; e.data = m_data; e.gid = m_gid; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("wr_en", wr_en, o.en);
    chk("wr_addr", wr_addr, o.addr);
    chk("wr_data", wr_data, o.data);
    chk("grant_id", grant_id, o.gid);
    chk("conflict_cnt", conflict_cnt, o.cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; req0 = 0; req1 = 0; stall = 0; cnt_clr = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    @(posedge clk); #1;
    tick(); tick();
    chk("reset_wr_addr", wr_addr, 5'd0);
    reset = 0;

    // Single requester 0
    req0 = 1; addr0 = 5'd3; data0 = 64'hAA;
    tick();
    chk("r34_wr_en", wr_en, 1'b1);
    chk("r34_wr_addr", wr_addr, 5'd3);
    chk("r34_wr_data", wr_data, 64'hAA);
    chk("r34_gid", grant_id, 1'b0);
    req0 = 0;
    tick();

    // Alternating dual requests starting from reset priority
    reset = 1; tick(); reset = 0;
    req0 = 1; req1 = 1; addr0 = 5'd1; addr1 = 5'd2; data0 = 64'h11; data1 = 64'h22;
    tick(); chk("r35_a0", wr_addr, 5'd1);
    tick(); chk("r35_a1", wr_addr, 5'd2);
    tick(); chk("r35_a2", wr_addr, 5'd1);
    tick(); chk("r35_a3", wr_addr, 5'd2);
    chk("r35_cnt", conflict_cnt, 4'd4);
    req0 = 0; req1 = 0;
    tick();

    // Write to the zero register is acked but not written
    req1 = 1; addr1 = 5'd31; data1 = 64'h55;
    tick();
    chk("r36_wr_en", wr_en, 1'b0);
    chk("r36_wr_data", wr_data, 64'h55);
    chk("r36_gid", grant_id, 1'b1);
    req1 = 0;
    tick();

    // Stall blocks grants but conflicts still count
    req0 = 1; req1 = 1; addr0 = 5'd4; addr1 = 5'd6; data0 = 64'h44; data1 = 64'h66;
    stall = 1;
    tick(); tick(); tick();
    chk("r37_cnt", conflict_cnt, 4'd7);
    stall = 0;
    tick();
    chk("r37_first_gid", grant_id, 1'b0);

    // Same destination: priority requester first, the other one's write lands last
    addr0 = 5'd7; addr1 = 5'd7; data0 = 64'h70; data1 = 64'h71;
    tick(); tick();
    chk("r27_last_data", wr_data, 64'h70);

    // Saturation and clear
    addr0 = 5'd8; addr1 = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    chk("r38_sat", conflict_cnt, 4'd15);
    cnt_clr = 1;
    tick();
    chk("r38_clr", conflict_cnt, 4'd0);
    cnt_clr = 0; req0 = 0; req1 = 0;
    tick();

    // Random back-to-back traffic
    for (int i = 0; i < 60; i++) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      addr0 = 5'($urandom); addr1 = 5'($urandom);
      data0 = {$urandom, $urandom}; data1 = {$urandom, $urandom};
      stall = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    stall = 0; cnt_clr = 0; req1 = 0;

    // Reset in the cycle of a grant cancels the write
    req0 = 1; addr0 = 5'd5; data0 = 64'h5A;
    reset = 1;
    tick();
    chk("r39_wr_en", wr_en, 1'b0);
    chk("r39_wr_addr", wr_addr, 5'd0);
    reset = 0;
    tick();
    chk("r39_wr_en_after", wr_en, 1'b1);
    chk("r39_wr_addr_after", wr_addr, 5'd5);
    req0 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter DATA_W, default 64: write data width.
REQ-002 Parameter ADDR_W, default 5: register address width.
REQ-003 Parameter ZERO_REG, default 31: hard-wired zero register index; writes to it are discarded.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 req0, req1  input  1 each  write request from requester 0 (ALU writeback) and requester 1 (memory writeback).
REQ-007 addr0, addr1  input  ADDR_W each  destination register of each request.
REQ-008 data0, data1  input  DATA_W each  write data of each request.
REQ-009 stall  input  1  pipeline stall; blocks all grants while high.
REQ-010 cnt_clr  input  1  clears conflict_cnt.
REQ-011 ack0, ack1  output  1 each  combinational; request accepted this cycle.
REQ-012 wr_en  output  1  registered register-file write enable.
REQ-013 wr_addr  output  ADDR_W  registered write address.
REQ-014 wr_data  output  DATA_W  registered write data.
REQ-015 grant_id  output  1  registered index of the last requester granted.
REQ-016 conflict_cnt  output  4  saturating count of cycles in which both requesters were present.

Function
REQ-017 Internal 1-bit priority pointer pri: pri=0 favours requester 0; pri=1 favours requester 1.
REQ-018 Grant, single requester: when exactly one req is high, stall=0, reset=0: that requester is acked, regardless of pri.
REQ-019 Grant, both requesters: when both req are high, stall=0, reset=0: only requester pri is acked.
REQ-020 ack0 and ack1 are never high in the same cycle.
REQ-021 When stall=1 or reset=1: ack0=ack1=0.
REQ-022 On any grant to requester i: pri <= ~i at the next edge; with no grant, pri holds.
REQ-023 Handshake: a requester holds req, addr and data stable until it sees ack. A req dropped before ack is legal and produces no write.
REQ-024 Latency: one cycle. On the edge after a grant to i: wr_addr <= addr_i, wr_data <= data_i, grant_id <= i, and wr_en <= 1 only if addr_i != ZERO_REG.
REQ-025 A grant to ZERO_REG is still acked and still updates wr_addr, wr_data, grant_id and pri, but wr_en <= 0.
REQ-026 With no grant in a cycle: wr_en <= 0; wr_addr, wr_data and grant_id hold their values.
REQ-027 Same destination address from both requesters in one cycle: the pri requester writes first; the other requester is granted next cycle if it is still requesting, so the later write wins.
REQ-028 conflict_cnt increments by 1 on each edge where req0=req1=1, independent of stall, and saturates at 15.
REQ-029 cnt_clr=1 sets conflict_cnt <= 0 and takes precedence over increment.
REQ-030 A back-to-back stream is legal: one grant per cycle, wr_en high every cycle with no bubbles.

Reset
REQ-031 While reset=1 at an edge: pri <= 0, wr_en <= 0, wr_addr <= 0, wr_data <= 0, grant_id <= 0, conflict_cnt <= 0.
REQ-032 A request pending during a reset cycle is not acked. It is arbitrated normally from the first cycle with reset=0, with pri=0.
REQ-033 Reset asserted mid-stream cancels any write that would have been registered at that edge; wr_en=0 in the following cycle.

Verification
REQ-034 After reset, req0=1, addr0=3, data0=0xAA, one cycle -> ack0=1 that cycle; next cycle wr_en=1, wr_addr=3, wr_data=0xAA, grant_id=0.
REQ-035 req0=req1=1 held with addr0=1, addr1=2 for 4 cycles after reset -> acks alternate 0,1,0,1; wr_addr sequence 1,2,1,2 with wr_en high throughout; conflict_cnt=4.
REQ-036 req1=1, addr1=31, data1=0x55 -> ack1=1; next cycle wr_en=0, wr_data=0x55, grant_id=1; pri flips to 0.
REQ-037 stall=1 for 3 cycles with both req high -> no ack, wr_en=0, pri unchanged, conflict_cnt +3. After stall drops, the pri requester is acked first.
REQ-038 20 cycles of dual requests, then cnt_clr=1 -> conflict_cnt reads 15 before the clear and 0 after it; with cnt_clr and dual request in the same cycle, result is 0.
REQ-039 Reset asserted in the cycle of a grant to addr 5 -> next cycle wr_en=0, wr_addr=0; a held req0 is acked in the first cycle after reset deasserts.
